// File: rtl/inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : inst_sequencer
// Purpose  : Multi-cycle FETCH/OP0/OP1/EXEC/WB sequencer between the five
//            processor FIFOs and the shared combinational ALU.
// Options  : SEQ_STALL_COUNT_EN adds a saturating 16-bit stall_count output.
// Revision : 1.0
// ============================================================================
module inst_sequencer #(
  parameter int DATA_WIDTH     = 4,
  parameter int INST_WIDTH     = 8,
  parameter int OPCODE_WIDTH   = 2,
  parameter int SRC0_IDX_WIDTH = 2,
  parameter int SRC1_IDX_WIDTH = 2,
  parameter int DST0_IDX_WIDTH = 1,
  parameter int DST1_IDX_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INST_WIDTH-1:0]   ctrl_fifo_data_out,
  input  logic                    ctrl_fifo_empty,
  output logic                    ctrl_fifo_deq,
  input  logic [DATA_WIDTH-1:0]   int_fifo_data_out,
  input  logic                    int_fifo_empty,
  output logic                    int_fifo_deq,
  input  logic [DATA_WIDTH-1:0]   nin_fifo_data_out,
  input  logic                    nin_fifo_empty,
  output logic                    nin_fifo_deq,
  input  logic                    nout_fifo_full,
  output logic                    nout_fifo_enq,
  output logic [DATA_WIDTH-1:0]   nout_fifo_data_in,
  input  logic                    bus_fifo_full,
  output logic                    bus_fifo_enq,
  output logic [DATA_WIDTH-1:0]   bus_fifo_data_in,
  output logic                    alu_enable,
  output logic [OPCODE_WIDTH-1:0] alu_op_code,
  output logic [DATA_WIDTH-1:0]   alu_op0,
  output logic [DATA_WIDTH-1:0]   alu_op1,
  input  logic [DATA_WIDTH-1:0]   alu_out,
  output logic                    busy,
  output logic [7:0]              inst_count
`ifdef SEQ_STALL_COUNT_EN
  ,
  output logic [15:0]             stall_count
`endif
);

  localparam int c_SRC0_LSB = INST_WIDTH - OPCODE_WIDTH - SRC0_IDX_WIDTH;
  localparam int c_SRC1_LSB = c_SRC0_LSB - SRC1_IDX_WIDTH;
  localparam int c_DST0_LSB = c_SRC1_LSB - DST0_IDX_WIDTH;
  localparam int c_DST1_LSB = c_DST0_LSB - DST1_IDX_WIDTH;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_OP0   = 3'd1,
    S_OP1   = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  state_t                  r_state;
  logic [INST_WIDTH-1:0]   r_inst;
  logic [DATA_WIDTH-1:0]   r_opnd0;
  logic [DATA_WIDTH-1:0]   r_opnd1;
  logic [DATA_WIDTH-1:0]   r_result;
  logic [7:0]              r_inst_count;

  logic [OPCODE_WIDTH-1:0]   w_op;
  logic [SRC0_IDX_WIDTH-1:0] w_src0;
  logic [SRC0_IDX_WIDTH-1:0] w_src1;
  logic [SRC0_IDX_WIDTH-1:0] w_src;
  logic                      w_dst0;
  logic                      w_dst1;
  logic                      w_in_op;
  logic                      w_src_avail;
  logic [DATA_WIDTH-1:0]     w_src_data;
  logic                      w_wb_ready;
  logic                      w_wb_fire;
  logic                      w_exec;

  assign w_op   = r_inst[INST_WIDTH-1 -: OPCODE_WIDTH];
  assign w_src0 = r_inst[c_SRC0_LSB +: SRC0_IDX_WIDTH];
  assign w_src1 = r_inst[c_SRC1_LSB +: SRC1_IDX_WIDTH];
  assign w_dst0 = r_inst[c_DST0_LSB];
  assign w_dst1 = r_inst[c_DST1_LSB];

  // OP0 and OP1 share one operand-selection path; only the field differs.
  assign w_in_op     = (r_state == S_OP0) || (r_state == S_OP1);
  assign w_src       = (r_state == S_OP1) ? w_src1 : w_src0;
  assign w_src_avail = w_src[1] | (w_src[0] ? !nin_fifo_empty : !int_fifo_empty);

  always_comb begin
    w_src_data = '0;
    case (w_src)
      2'b00:   w_src_data = int_fifo_data_out;
      2'b01:   w_src_data = nin_fifo_data_out;
      default: w_src_data = {{(DATA_WIDTH-1){1'b0}}, w_src[0]};
    endcase
  end

  assign w_wb_ready = !(w_dst0 && nout_fifo_full) && !(w_dst1 && bus_fifo_full);
  assign w_wb_fire  = (r_state == S_WB) && w_wb_ready;
  assign w_exec     = !reset && (r_state == S_EXEC);

  // Strobes are masked during reset so an aborted instruction loses no further entries.
  assign ctrl_fifo_deq = !reset && (r_state == S_FETCH) && !ctrl_fifo_empty;
  assign int_fifo_deq  = !reset && w_in_op && (w_src == 2'b00) && !int_fifo_empty;
  assign nin_fifo_deq  = !reset && w_in_op && (w_src == 2'b01) && !nin_fifo_empty;
  assign nout_fifo_enq = !reset && w_wb_fire && w_dst0;
  assign bus_fifo_enq  = !reset && w_wb_fire && w_dst1;

  assign nout_fifo_data_in = r_result;
  assign bus_fifo_data_in  = r_result;

  assign alu_enable  = w_exec;
  assign alu_op_code = w_exec ? w_op    : '0;
  assign alu_op0     = w_exec ? r_opnd0 : '0;
  assign alu_op1     = w_exec ? r_opnd1 : '0;

  assign busy       = !reset && (r_state != S_FETCH);
  assign inst_count = r_inst_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_inst       <= '0;
      r_opnd0      <= '0;
      r_opnd1      <= '0;
      r_result     <= '0;
      r_inst_count <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!ctrl_fifo_empty) begin
            r_inst  <= ctrl_fifo_data_out;
            r_state <= S_OP0;
          end
        end
        S_OP0: begin
          if (w_src_avail) begin
            r_opnd0 <= w_src_data;
            r_state <= S_OP1;
          end
        end
        S_OP1: begin
          if (w_src_avail) begin
            r_opnd1 <= w_src_data;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= alu_out;
          r_state  <= S_WB;
        end
        S_WB: begin
          if (w_wb_ready) begin
            r_inst_count <= r_inst_count + 8'd1;
            r_state      <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

`ifdef SEQ_STALL_COUNT_EN
  logic [15:0] r_stall_count;
  logic        w_stall;

  assign w_stall = (w_in_op && !w_src_avail) || ((r_state == S_WB) && !w_wb_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_sequencer
// Purpose  : Directed self-checking bench for inst_sequencer with behavioural
//            FIFOs and ALU; stall_count checked when SEQ_STALL_COUNT_EN is set.
// Revision : 1.0
// ============================================================================
module tb_inst_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] ctrl_fifo_data_out;
  logic       ctrl_fifo_empty, ctrl_fifo_deq;
  logic [3:0] int_fifo_data_out;
  logic       int_fifo_empty, int_fifo_deq;
  logic [3:0] nin_fifo_data_out;
  logic       nin_fifo_empty, nin_fifo_deq;
  logic       nout_fifo_full, nout_fifo_enq;
  logic [3:0] nout_fifo_data_in;
  logic       bus_fifo_full, bus_fifo_enq;
  logic [3:0] bus_fifo_data_in;
  logic       alu_enable;
  logic [1:0] alu_op_code;
  logic [3:0] alu_op0, alu_op1, alu_out;
  logic       busy;
  logic [7:0] inst_count;
`ifdef SEQ_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  inst_sequencer dut (
    .clk(clk), .reset(reset),
    .ctrl_fifo_data_out(ctrl_fifo_data_out), .ctrl_fifo_empty(ctrl_fifo_empty),
    .ctrl_fifo_deq(ctrl_fifo_deq),
    .int_fifo_data_out(int_fifo_data_out), .int_fifo_empty(int_fifo_empty),
    .int_fifo_deq(int_fifo_deq),
    .nin_fifo_data_out(nin_fifo_data_out), .nin_fifo_empty(nin_fifo_empty),
    .nin_fifo_deq(nin_fifo_deq),
    .nout_fifo_full(nout_fifo_full), .nout_fifo_enq(nout_fifo_enq),
    .nout_fifo_data_in(nout_fifo_data_in),
    .bus_fifo_full(bus_fifo_full), .bus_fifo_enq(bus_fifo_enq),
    .bus_fifo_data_in(bus_fifo_data_in),
    .alu_enable(alu_enable), .alu_op_code(alu_op_code),
    .alu_op0(alu_op0), .alu_op1(alu_op1), .alu_out(alu_out),
    .busy(busy), .inst_count(inst_count)
`ifdef SEQ_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 00 add, 01 sub, 10 and, 11 or.
  always_comb begin
    alu_out = '0;
    case (alu_op_code)
      2'b00:   alu_out = alu_op0 + alu_op1;
      2'b01:   alu_out = alu_op0 - alu_op1;
      2'b10:   alu_out = alu_op0 & alu_op1;
      default: alu_out = alu_op0 | alu_op1;
    endcase
  end

  logic [7:0] ctrl_mem [512];
  logic [3:0] int_mem  [64];
  logic [3:0] nin_mem  [64];
  int ctrl_wr = 0, ctrl_rd = 0;
  int int_wr = 0, int_rd = 0;
  int nin_wr = 0, nin_rd = 0;
  int cyc = 0;

  assign ctrl_fifo_empty    = (ctrl_rd == ctrl_wr);
  assign ctrl_fifo_data_out = ctrl_mem[ctrl_rd[8:0]];
  assign int_fifo_empty     = (int_rd == int_wr);
  assign int_fifo_data_out  = int_mem[int_rd[5:0]];
  assign nin_fifo_empty     = (nin_rd == nin_wr);
  assign nin_fifo_data_out  = nin_mem[nin_rd[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ctrl_fifo_deq) ctrl_rd <= ctrl_rd + 1;
    if (int_fifo_deq)  int_rd  <= int_rd + 1;
    if (nin_fifo_deq)  nin_rd  <= nin_rd + 1;
  end

  int ctrl_deq_cyc = -1, int_deq_cyc = -1, int_prev_cyc = -1, nin_deq_cyc = -1;
  int nout_cyc = -1, bus_cyc = -1;
  int n_int_deq = 0, n_nin_deq = 0, n_nout = 0, n_bus = 0, n_viol = 0;
  logic [3:0] nout_val = '0, bus_val = '0;
  logic [1:0] alu_last_op = '0;

  // Mid-cycle observer: logs strobes and counts protocol violations.
  always @(negedge clk) begin
    if (ctrl_fifo_deq) begin
      ctrl_deq_cyc = cyc;
      if (ctrl_fifo_empty) n_viol++;
    end
    if (int_fifo_deq) begin
      int_prev_cyc = int_deq_cyc;
      int_deq_cyc  = cyc;
      n_int_deq++;
      if (int_fifo_empty) n_viol++;
    end
    if (nin_fifo_deq) begin
      nin_deq_cyc = cyc;
      n_nin_deq++;
      if (nin_fifo_empty) n_viol++;
    end
    if (nout_fifo_enq) begin
      nout_cyc = cyc;
      nout_val = nout_fifo_data_in;
      n_nout++;
      if (nout_fifo_full) n_viol++;
    end
    if (bus_fifo_enq) begin
      bus_cyc = cyc;
      bus_val = bus_fifo_data_in;
      n_bus++;
      if (bus_fifo_full) n_viol++;
    end
    if (alu_enable) alu_last_op = alu_op_code;
    else if (alu_op0 != 4'd0 || alu_op1 != 4'd0 || alu_op_code != 2'd0) n_viol++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ctrl(input logic [7:0] v);
    ctrl_mem[ctrl_wr[8:0]] = v;
    ctrl_wr++;
  endtask

  task automatic push_int(input logic [3:0] v);
    int_mem[int_wr[5:0]] = v;
    int_wr++;
  endtask

  task automatic push_nin(input logic [3:0] v);
    nin_mem[nin_wr[5:0]] = v;
    nin_wr++;
  endtask

  task automatic wait_retire(input logic [7:0] target, input string tag);
    for (int i = 0; i < 40 && inst_count != target; i++) step();
    check(tag, 32'(inst_count), 32'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int s, ni, nn, no, nb, max_cnt;
    reset = 1'b1;
    nout_fifo_full = 1'b0;
    bus_fifo_full  = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    check("rst_busy", 32'(busy), 0);
    check("rst_inst_count", 32'(inst_count), 0);
    check("rst_alu_enable", 32'(alu_enable), 0);
    check("rst_nout_data", 32'(nout_fifo_data_in), 0);
    check("rst_bus_data", 32'(bus_fifo_data_in), 0);
`ifdef SEQ_STALL_COUNT_EN
    check("rst_stall", 32'(stall_count), 0);
`endif

    // int + nin, add, to nout
    push_int(4'd3); push_nin(4'd4); push_ctrl(8'b00_00_01_1_0);
    s = cyc;
    wait_retire(8'd1, "t1_count");
    check("t1_ctrl_cyc", ctrl_deq_cyc, s);
    check("t1_int_cyc", int_deq_cyc, s + 1);
    check("t1_nin_cyc", nin_deq_cyc, s + 2);
    check("t1_latency", nout_cyc - ctrl_deq_cyc, 4);
    check("t1_nout_val", 32'(nout_val), 7);
    check("t1_no_bus", n_bus, 0);

    // AND opcode reaches the ALU
    push_int(4'd6); push_nin(4'd3); push_ctrl(8'b10_00_01_1_0);
    wait_retire(8'd2, "t1b_count");
    check("t1b_nout_val", 32'(nout_val), 2);
    check("t1b_alu_op", 32'(alu_last_op), 2);

    // both operands from int FIFO, to bus
    push_int(4'd2); push_int(4'd5); push_ctrl(8'b00_00_00_0_1);
    s = cyc;
    wait_retire(8'd3, "t2_count");
    check("t2_int_consec", int_deq_cyc - int_prev_cyc, 1);
    check("t2_int_cyc", int_deq_cyc, s + 2);
    check("t2_bus_val", 32'(bus_val), 7);
    check("t2_nout_untouched", n_nout, 2);

    // immediates, both destinations, nout full for 3 WB cycles
    nout_fifo_full = 1'b1;
    ni = n_int_deq; nn = n_nin_deq;
    push_ctrl(8'b00_10_11_1_1);
    s = cyc;
    repeat (7) step();
    nout_fifo_full = 1'b0;
    wait_retire(8'd4, "t3_count");
    check("t3_enq_cyc", nout_cyc - s, 7);
    check("t3_same_cycle", bus_cyc, nout_cyc);
    check("t3_nout_val", 32'(nout_val), 1);
    check("t3_bus_val", 32'(bus_val), 1);
    check("t3_no_int_deq", n_int_deq, ni);
    check("t3_no_nin_deq", n_nin_deq, nn);
`ifdef SEQ_STALL_COUNT_EN
    check("t3_stall", 32'(stall_count), 3);
`endif

    // nin empty for 6 cycles in OP0
    push_ctrl(8'b00_01_10_1_0);
    s = cyc;
    repeat (7) step();
    push_nin(4'd9);
    wait_retire(8'd5, "t4_count");
    check("t4_nin_cyc", nin_deq_cyc, s + 7);
    check("t4_nout_val", 32'(nout_val), 9);
    check("t4_nout_cyc", nout_cyc, s + 10);
`ifdef SEQ_STALL_COUNT_EN
    check("t4_stall", 32'(stall_count), 9);
`endif

    // reset while in OP1 aborts the instruction
    nn = n_nin_deq; no = n_nout; nb = n_bus;
    push_int(4'd5); push_nin(4'd6); push_ctrl(8'b00_00_01_1_1);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_busy", 32'(busy), 0);
    check("t5_inst_count", 32'(inst_count), 0);
    check("t5_nin_kept", n_nin_deq, nn);
`ifdef SEQ_STALL_COUNT_EN
    check("t5_stall", 32'(stall_count), 0);
`endif
    repeat (5) step();
    check("t5_no_nout", n_nout, no);
    check("t5_no_bus", n_bus, nb);
    push_int(4'd1); push_ctrl(8'b00_00_01_1_0);
    wait_retire(8'd1, "t5_next_count");
    check("t5_next_val", 32'(nout_val), 7);

    // 256 discard instructions wrap inst_count
    reset = 1'b1;
    step();
    reset = 1'b0;
    no = n_nout; nb = n_bus; max_cnt = 0;
    for (int i = 0; i < 256; i++) push_ctrl(8'b00_10_11_0_0);
    for (int i = 0; i < 2000 && !(ctrl_rd == ctrl_wr && !busy); i++) begin
      step();
      if (int'(inst_count) > max_cnt) max_cnt = int'(inst_count);
    end
    check("t6_drained", ctrl_rd, ctrl_wr);
    check("t6_peak", max_cnt, 255);
    check("t6_wrap", 32'(inst_count), 0);
    check("t6_no_nout", n_nout, no);
    check("t6_no_bus", n_bus, nb);

    check("protocol_violations", n_viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
